led_pattern_ctrl: RTL and testbench

Sequencer for the 4-LED bank on the 50 MHz board. It owns the step timebase and the LED register, and selects between four display patterns from two push-keys. It also offers four step speeds and a pause input. It replaces a free-running fixed rotate with a user-controlled pattern scheduler.

---
 rtl/led_pattern_ctrl.sv | 169 ++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: debounced mode/speed keys, step timebase and four display patterns.
// Optional macro LED_ACTIVE_LOW_EN inverts the led port for active-low LED drive.
`timescale 1ns/1ps
module led_pattern_ctrl #(
  parameter int unsigned TICK_MAX = 10000000,
  parameter int unsigned DEB_MAX  = 1000000
) (
  input  logic       sys_clk50,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_speed,
  input  logic       pause,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       step_tick
);

  typedef enum logic [1:0] {
    FLOW_L   = 2'b00,
    FLOW_R   = 2'b01,
    BLINK    = 2'b10,
    PINGPONG = 2'b11
  } mode_t;

  localparam logic [23:0] TICK_P   = 24'(TICK_MAX);
  localparam logic [19:0] DEB_LAST = 20'(DEB_MAX - 1);

  // Key path, bit 0 = mode key, bit 1 = speed key.
  logic [1:0]  key_raw;
  logic [1:0]  sync1_q, sync2_q;
  logic [1:0]  stable_q, stable_d1_q;
  logic [1:0]  armed_q;
  logic [1:0]  press;
  logic [19:0] deb_cnt_q [2];
  logic        mode_press, speed_press;

  assign key_raw = {key_speed, key_mode};

  // Synchronizers reset to "pressed" so armed_q only sets once a real
  // release has been observed; a key held through reset stays silent.
  always_ff @(posedge sys_clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      stable_q    <= 2'b11;
      stable_d1_q <= 2'b11;
      armed_q     <= 2'b00;
      for (int k = 0; k < 2; k++) deb_cnt_q[k] <= '0;
    end else begin
      sync1_q     <= key_raw;
      sync2_q     <= sync1_q;
      stable_d1_q <= stable_q;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k]) armed_q[k] <= 1'b1;
        if (sync2_q[k] == stable_q[k]) begin
          deb_cnt_q[k] <= '0;
        end else if (deb_cnt_q[k] == DEB_LAST) begin
          stable_q[k]  <= sync2_q[k];
          deb_cnt_q[k] <= '0;
        end else begin
          deb_cnt_q[k] <= deb_cnt_q[k] + 20'd1;
        end
      end
    end
  end

  assign press       = armed_q & stable_d1_q & ~stable_q;
  assign mode_press  = press[0];
  assign speed_press = press[1];

  // Pattern scheduler state.
  mode_t       state_q, state_d;
  logic [3:0]  pat_q, pat_d;
  logic        dir_up_q, dir_up_d;
  logic [1:0]  speed_q, speed_d;
  logic [23:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic [23:0] period;
  logic        term;

  assign period = TICK_P >> speed_q;
  // >= rather than == keeps the counter bounded if the period ever shrinks under it.
  assign term   = (cnt_q >= (period - 24'd1));

  function automatic logic [3:0] init_pat(input mode_t m);
    case (m)
      FLOW_R:  init_pat = 4'b1000;
      BLINK:   init_pat = 4'b1111;
      default: init_pat = 4'b0001;
    endcase
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      FLOW_L:  next_mode = FLOW_R;
      FLOW_R:  next_mode = BLINK;
      BLINK:   next_mode = PINGPONG;
      default: next_mode = FLOW_L;
    endcase
  endfunction

  always_ff @(posedge sys_clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FLOW_L;
      pat_q    <= 4'b0001;
      dir_up_q <= 1'b1;
      speed_q  <= 2'd0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      dir_up_q <= dir_up_d;
      speed_q  <= speed_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    dir_up_d = dir_up_q;
    speed_d  = speed_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    if (speed_press) begin
      speed_d = speed_q + 2'd1;
      cnt_d   = '0;
    end
    // A mode press overrides any step due in the same cycle.
    if (mode_press) begin
      state_d  = next_mode(state_q);
      pat_d    = init_pat(next_mode(state_q));
      dir_up_d = 1'b1;
      cnt_d    = '0;
    end else if (!speed_press && !pause) begin
      if (term) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        case (state_q)
          FLOW_L: pat_d = {pat_q[2:0], pat_q[3]};
          FLOW_R: pat_d = {pat_q[0], pat_q[3:1]};
          BLINK:  pat_d = ~pat_q;
          default: begin
            if (dir_up_q) begin
              pat_d = pat_q << 1;
              if (pat_q[2]) dir_up_d = 1'b0;
            end else begin
              pat_d = pat_q >> 1;
              if (pat_q[1]) dir_up_d = 1'b1;
            end
          end
        endcase
      end else begin
        cnt_d = cnt_q + 24'd1;
      end
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~pat_q;
`else
  assign led = pat_q;
`endif
  assign mode      = state_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with TICK_MAX=8, DEB_MAX=4 (default led polarity).
`timescale 1ns/1ps
module tb_led_pattern_ctrl;

  logic       sys_clk50 = 1'b0;
  logic       rst_n     = 1'b0;
  logic       key_mode  = 1'b1;
  logic       key_speed = 1'b1;
  logic       pause     = 1'b0;
  logic [3:0] led;
  logic [1:0] mode;
  logic       step_tick;

  int n_cmp = 0;
  int n_bad = 0;

  led_pattern_ctrl #(.TICK_MAX(8), .DEB_MAX(4)) dut (
    .sys_clk50 (sys_clk50),
    .rst_n     (rst_n),
    .key_mode  (key_mode),
    .key_speed (key_speed),
    .pause     (pause),
    .led       (led),
    .mode      (mode),
    .step_tick (step_tick)
  );

  // Clock / watchdog
  always #10 sys_clk50 = ~sys_clk50;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Checking and driver tasks
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk50);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge sys_clk50);
      n++;
    end while (!step_tick && n < 64);
  endtask

  task automatic mode_press(output int lat);
    logic [1:0] m0;
    m0 = mode;
    key_mode = 1'b0;
    lat = 0;
    do begin
      @(negedge sys_clk50);
      lat++;
    end while (mode == m0 && lat < 32);
  endtask

  task automatic release_mode();
    key_mode = 1'b1;
    cycles(12);
  endtask

  task automatic speed_press();
    key_speed = 1'b0;
    cycles(10);
    key_speed = 1'b1;
    cycles(10);
  endtask

  // Stimulus
  initial begin
    int n;
    int lat;
    bit saw_tick;
    bit led_moved;
    logic [3:0] flow_exp [4];
    logic [3:0] pp_exp [7];
    int spd_exp [4];
    flow_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    pp_exp   = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    spd_exp  = '{4, 2, 1, 8};

    // Reset state and free-running FLOW_L
    cycles(2);
    check_eq("rst_led", led, 4'b0001);
    check_eq("rst_mode", mode, 2'b00);
    check_eq("rst_tick", step_tick, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick(n);
      check_eq("flow_l_spacing", n, 8);
      check_eq("flow_l_led", led, flow_exp[i]);
    end

    // Short glitch on the mode key is filtered
    key_mode = 1'b0;
    cycles(3);
    key_mode = 1'b1;
    cycles(10);
    check_eq("glitch_mode", mode, 2'b00);

    // Clean press -> FLOW_R
    mode_press(lat);
    check_eq("press_latency", lat, 7);
    check_eq("flow_r_mode", mode, 2'b01);
    check_eq("flow_r_init", led, 4'b1000);
    check_eq("flow_r_tick0", step_tick, 1'b0);
    wait_tick(n);
    check_eq("flow_r_cnt_clr", n, 8);
    check_eq("flow_r_step", led, 4'b0100);
    release_mode();

    // BLINK
    mode_press(lat);
    check_eq("blink_mode", mode, 2'b10);
    check_eq("blink_init", led, 4'b1111);
    wait_tick(n);
    check_eq("blink_step", led, 4'b0000);
    release_mode();

    // PINGPONG: init then seven steps
    mode_press(lat);
    check_eq("pp_mode", mode, 2'b11);
    check_eq("pp_init", led, 4'b0001);
    for (int i = 0; i < 7; i++) begin
      wait_tick(n);
      check_eq("pp_spacing", n, 8);
      check_eq("pp_led", led, pp_exp[i]);
    end
    release_mode();

    // Speed steps 4, 2, 1, back to 8
    for (int i = 0; i < 4; i++) begin
      speed_press();
      wait_tick(n);
      wait_tick(n);
      check_eq("speed_spacing", n, spd_exp[i]);
    end

    // Back to FLOW_L, then pause mid-count
    mode_press(lat);
    check_eq("wrap_mode", mode, 2'b00);
    check_eq("wrap_init", led, 4'b0001);
    wait_tick(n);
    check_eq("wrap_spacing", n, 8);
    cycles(3);
    pause = 1'b1;
    saw_tick = 1'b0;
    led_moved = 1'b0;
    repeat (20) begin
      @(negedge sys_clk50);
      if (step_tick) saw_tick = 1'b1;
      if (led !== 4'b0010) led_moved = 1'b1;
    end
    check_eq("pause_no_tick", saw_tick, 1'b0);
    check_eq("pause_led_frozen", led_moved, 1'b0);
    pause = 1'b0;
    wait_tick(n);
    check_eq("resume_remaining", n, 5);
    check_eq("resume_led", led, 4'b0100);
    release_mode();

    // Mode press while paused reloads init and stays frozen
    wait_tick(n);
    cycles(2);
    pause = 1'b1;
    mode_press(lat);
    check_eq("paused_mode", mode, 2'b01);
    check_eq("paused_init", led, 4'b1000);
    key_mode = 1'b1;
    saw_tick = 1'b0;
    led_moved = 1'b0;
    repeat (20) begin
      @(negedge sys_clk50);
      if (step_tick) saw_tick = 1'b1;
      if (led !== 4'b1000) led_moved = 1'b1;
    end
    check_eq("paused_no_tick", saw_tick, 1'b0);
    check_eq("paused_led_frozen", led_moved, 1'b0);
    pause = 1'b0;
    wait_tick(n);
    check_eq("unpause_spacing", n, 8);
    check_eq("unpause_led", led, 4'b0100);

    // Mode press lands on the terminal-count cycle
    cycles(1);
    mode_press(lat);
    check_eq("tc_latency", lat, 7);
    check_eq("tc_mode", mode, 2'b10);
    check_eq("tc_led", led, 4'b1111);
    check_eq("tc_no_tick", step_tick, 1'b0);
    wait_tick(n);
    check_eq("tc_next_spacing", n, 8);
    check_eq("tc_next_led", led, 4'b0000);
    release_mode();

    // Asynchronous reset mid-count, with speed raised beforehand
    speed_press();
    wait_tick(n);
    cycles(2);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_led", led, 4'b0001);
    check_eq("arst_mode", mode, 2'b00);
    check_eq("arst_tick", step_tick, 1'b0);
    @(negedge sys_clk50);
    rst_n = 1'b1;
    wait_tick(n);
    check_eq("arst_speed_clr", n, 8);
    check_eq("arst_led_step", led, 4'b0010);

    // Key held across reset release produces no event until re-pressed
    rst_n = 1'b0;
    key_mode = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    check_eq("held_no_event", mode, 2'b00);
    key_mode = 1'b1;
    cycles(12);
    check_eq("held_release", mode, 2'b00);
    mode_press(lat);
    check_eq("held_repress_lat", lat, 7);
    check_eq("held_repress_mode", mode, 2'b01);
    release_mode();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
